// File: rtl/imm_gen_pipe.sv
// RV32I immediate generator with a 2-entry skid FIFO between a valid/ready
// input and a valid/ready output; immediates are decoded on acceptance.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] Tag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] TagOut,
  output logic             IllegalImm
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_ZIMM  = 3'b110;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;

  logic [31:0]     asm_imm;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  entry_t          new_entry;
  logic            push;
  logic            pop;

  // Opcode bits carry no immediate content.
  logic unused_opcode;
  assign unused_opcode = ^Instr[6:0];

  // Signed formats are assembled to 32 bits first, then sign-extended to XLEN.
  always_comb begin
    asm_imm = '0;
    dec_imm = '0;
    dec_ill = 1'b0;
    unique case (ImmSrc)
      SRC_I: begin
        asm_imm = {{20{Instr[31]}}, Instr[31:20]};
        dec_imm = XLEN'(signed'(asm_imm));
      end
      SRC_S: begin
        asm_imm = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
        dec_imm = XLEN'(signed'(asm_imm));
      end
      SRC_B: begin
        asm_imm = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
        dec_imm = XLEN'(signed'(asm_imm));
      end
      SRC_J: begin
        asm_imm = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
        dec_imm = XLEN'(signed'(asm_imm));
      end
      SRC_U: begin
        asm_imm = {Instr[31:12], 12'b0};
        dec_imm = XLEN'(signed'(asm_imm));
      end
      SRC_SHAMT: begin
        if (XLEN == 64) begin
          dec_imm = XLEN'(Instr[25:20]);
        end else begin
          dec_imm = XLEN'(Instr[24:20]);
          dec_ill = Instr[25];
        end
      end
      SRC_ZIMM: begin
        dec_imm = XLEN'(Instr[19:15]);
      end
      default: begin
        dec_imm = '0;
        dec_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    new_entry.imm     = dec_imm;
    new_entry.tag     = Tag;
    new_entry.illegal = dec_ill;
  end

  assign InReady  = (state_q != ST_TWO);
  assign OutValid = (state_q != ST_EMPTY);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;

  // Head always holds the oldest entry; tail is only occupied in ST_TWO.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_d  = new_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            tail_d  = new_entry;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign ImmExt     = OutValid ? head_q.imm     : '0;
  assign TagOut     = OutValid ? head_q.tag     : '0;
  assign IllegalImm = OutValid ? head_q.illegal : 1'b0;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Parameters
REQ-001 The block SHALL have parameter XLEN, default 32, giving the immediate output width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter TAG_W, default 5, giving the width of the sideband tag carried with each instruction.

Interface
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Flush  in  1  synchronous discard of all buffered entries.
REQ-006 InValid  in  1  upstream offers Instr/ImmSrc/Tag.
REQ-007 InReady  out  1  block can accept; transfer when InValid && InReady.
REQ-008 Instr  in  32  raw RV32I instruction word.
REQ-009 ImmSrc  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT, 110 ZIMM (CSR), 111 reserved.
REQ-010 Tag  in  TAG_W  opaque sideband, returned unchanged.
REQ-011 OutValid  out  1  ImmExt/TagOut/IllegalImm valid.
REQ-012 OutReady  in  1  downstream accepts; transfer when OutValid && OutReady.
REQ-013 ImmExt  out  XLEN  extended immediate.
REQ-014 TagOut  out  TAG_W  Tag of the entry presented.
REQ-015 IllegalImm  out  1  entry has an unsupported format or encoding.

Function
REQ-016 Immediates SHALL be computed at acceptance and stored with the entry: I = sext(Instr[31:20]); S = sext({Instr[31:25],Instr[11:7]}); B = sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}); J = sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}); U = sext({Instr[31:12],12'b0}); sext extends bit 31 of the assembled value (or its MSB) to XLEN.
REQ-017 SHAMT SHALL zero-extend Instr[24:20] when XLEN=32 and Instr[25:20] when XLEN=64; when XLEN=32 and Instr[25]=1, IllegalImm SHALL be 1 for that entry.
REQ-018 ZIMM SHALL zero-extend Instr[19:15] to XLEN.
REQ-019 ImmSrc=111 SHALL produce ImmExt=0 and IllegalImm=1; all other formats produce IllegalImm=0 except as stated in REQ-017.
REQ-020 Storage SHALL be a 2-entry FIFO (skid buffer) with states EMPTY, ONE and TWO; output order SHALL equal acceptance order.
REQ-021 InReady SHALL be 1 in EMPTY and ONE and 0 in TWO; it SHALL be derived from state only and never from InValid or OutReady.
REQ-022 OutValid SHALL be 1 in ONE and TWO, presenting the oldest entry.
REQ-023 Latency SHALL be 1 cycle: an entry accepted in EMPTY at edge N is presented at OutValid from edge N.
REQ-024 Transitions: EMPTY+push->ONE; ONE+push-only->TWO; ONE+pop-only->EMPTY; ONE+push+pop->ONE; TWO+pop->ONE; no event->hold.
REQ-025 While OutValid=1 and OutReady=0, ImmExt, TagOut and IllegalImm SHALL remain stable.
REQ-026 Flush=1 SHALL force EMPTY at the next edge; any push or pop in the same cycle SHALL be discarded with no output transfer counted.
REQ-027 Output data SHALL read as all zeros when OutValid=0.

Reset
REQ-028 reset=1 at a rising edge SHALL force EMPTY, giving OutValid=0, InReady=1, and ImmExt, TagOut and IllegalImm all 0 after that edge.
REQ-029 Reset SHALL take priority over Flush, InValid and OutReady, and assertion mid-operation SHALL discard all buffered entries.

Verification
REQ-030 XLEN=32, OutReady=1, push Instr=0xFFF00093 with ImmSrc=000 -> ImmExt=0xFFFFFFFF, IllegalImm=0, OutValid for exactly 1 cycle, 1 cycle after acceptance.
REQ-031 Push Instr=0xFE000EE3 with ImmSrc=010 -> ImmExt=0xFFFFFFFC; then push SHAMT with Instr[25]=1 -> IllegalImm=1.
REQ-032 XLEN=64, push Instr=0x800000B7 with ImmSrc=100 -> ImmExt=0xFFFFFFFF80000000.
REQ-033 Hold OutReady=0 and push tags 1, 2, 3 -> InReady=0 after tag 2 and tag 3 stalls; raise OutReady -> TagOut 1, 2, 3 in order with data stable while stalled.
REQ-034 State TWO, assert Flush with InValid=1 -> next cycle OutValid=0 and InReady=1, and no entry is emitted afterwards.
REQ-035 State ONE, assert reset for 1 cycle with InValid=1 -> all outputs 0 and InReady=1 afterwards, and the pre-reset entry is never emitted.
